// File: rtl/btn_in_pkg.sv
// Shared types and helpers for the button input path: event FSM encoding,
// index-width calculation and lowest-set-bit priority encoder.
package btn_in_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } evt_state_t;

    function automatic int unsigned idx_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: 2-FF synchroniser, tick-driven debounce counter, debounced level
// and registered rise/fall pulses.
module btn_debounce #(
    parameter int unsigned DB_TICKS = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    input  logic i_tick,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int unsigned CW = $clog2(DB_TICKS + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = (r_sync2 != r_level);
    assign w_flip = i_tick && w_diff && (r_cnt == CW'(DB_TICKS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= w_flip && !r_level;
            r_fall  <= w_flip && r_level;
            // Counter only moves on ticks; any agreeing sample restarts it
            if (i_tick) begin
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/btn_in.sv
// Button input path: prescaled debounce of WIDTH buttons, press events over valid/ready.
// Optional release events when BTN_RELEASE_EVT_EN is defined.
module btn_in
    import btn_in_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 10,
    parameter int unsigned DB_TICKS = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WIDTH-1:0]         i_btn,
    output logic [WIDTH-1:0]         o_level,
    output logic [WIDTH-1:0]         o_press,
    output logic                     o_evt_valid,
    input  logic                     i_evt_ready,
    output logic [idx_w(WIDTH)-1:0]  o_evt_index,
    output logic                     o_evt_rel,
    output logic                     o_overrun
);
    localparam int unsigned IW = idx_w(WIDTH);
    localparam int unsigned PW = (STEP < 2) ? 1 : $clog2(STEP);

    logic [PW-1:0]    r_pre;
    logic             w_tick;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] r_pend_p;
    logic [WIDTH-1:0] w_pend_r;
    logic [WIDTH-1:0] w_clr_p;
    logic [WIDTH-1:0] w_clr_r;
    logic             w_ovr_r;
    logic             w_load;
    logic             w_sel_rel;
    logic [IW-1:0]    w_sel_idx;
    logic             r_evt_valid;
    logic [IW-1:0]    r_evt_index;
    logic             r_overrun;
    evt_state_t       r_state;
    evt_state_t       w_state_nx;

    assign w_tick = (r_pre == PW'(STEP - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_db
        btn_debounce #(.DB_TICKS(DB_TICKS)) u_db (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_btn   (i_btn[g]),
            .i_tick  (w_tick),
            .o_level (o_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign o_press = w_rise;

`ifdef BTN_RELEASE_EVT_EN
    logic [WIDTH-1:0] r_pend_r;
    logic             r_evt_rel;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend_r  <= '0;
            r_evt_rel <= 1'b0;
        end else begin
            r_pend_r <= (r_pend_r & ~w_clr_r) | w_fall;
            if (w_load) r_evt_rel <= w_sel_rel;
        end
    end

    assign w_pend_r  = r_pend_r;
    assign w_ovr_r   = |(w_fall & r_pend_r & ~w_clr_r);
    assign o_evt_rel = r_evt_rel;
`else
    logic w_unused;

    assign w_pend_r  = '0;
    assign w_ovr_r   = 1'b0;
    assign o_evt_rel = 1'b0;
    assign w_unused  = ^{w_fall, w_clr_r, w_sel_rel};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:    if ((|r_pend_p) || (|w_pend_r)) w_state_nx = S_PRESENT;
            S_PRESENT: if (r_evt_valid && i_evt_ready) w_state_nx = S_IDLE;
        endcase
    end

    // Event selection: lowest pending press first, then lowest pending release
    always_comb begin
        w_load    = 1'b0;
        w_sel_rel = 1'b0;
        w_sel_idx = '0;
        w_clr_p   = '0;
        w_clr_r   = '0;
        if (r_state == S_IDLE) begin
            if (|r_pend_p) begin
                w_load    = 1'b1;
                w_sel_idx = IW'(lowest_set(32'(r_pend_p)));
                w_clr_p   = WIDTH'(1) << w_sel_idx;
            end else if (|w_pend_r) begin
                w_load    = 1'b1;
                w_sel_rel = 1'b1;
                w_sel_idx = IW'(lowest_set(32'(w_pend_r)));
                w_clr_r   = WIDTH'(1) << w_sel_idx;
            end
        end
    end

    // A new edge on a bit being loaded this cycle is a fresh event, not a loss
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend_p    <= '0;
            r_overrun   <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_index <= '0;
        end else begin
            r_pend_p <= (r_pend_p & ~w_clr_p) | w_rise;
            if ((|(w_rise & r_pend_p & ~w_clr_p)) || w_ovr_r) r_overrun <= 1'b1;
            if (w_load) begin
                r_evt_valid <= 1'b1;
                r_evt_index <= w_sel_idx;
            end else if (r_evt_valid && i_evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign o_evt_valid = r_evt_valid;
    assign o_evt_index = r_evt_index;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_btn_in.sv
// Scoreboard bench for btn_in (WIDTH=8, STEP=2, DB_TICKS=3); release expectations
// follow BTN_RELEASE_EVT_EN.
module tb_btn_in;

    typedef struct packed {
        logic [2:0] idx;
        logic       rel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] btn;
    logic [7:0] level;
    logic [7:0] press;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_index;
    logic       evt_rel;
    logic       overrun;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   p3_cnt  = 0;
    int   l3_rise = 0;
    logic l3_prev = 1'b0;

    always #5 clk = ~clk;

    btn_in #(.WIDTH(8), .STEP(2), .DB_TICKS(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_btn       (btn),
        .o_level     (level),
        .o_press     (press),
        .o_evt_valid (evt_valid),
        .i_evt_ready (evt_ready),
        .o_evt_index (evt_index),
        .o_evt_rel   (evt_rel),
        .o_overrun   (overrun)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push(input int idx, input logic rel);
        exp_t e;
        e.idx = 3'(idx);
        e.rel = rel;
        q.push_back(e);
    endtask

    task automatic push_rel(input int idx);
`ifdef BTN_RELEASE_EVT_EN
        push(idx, 1'b1);
`else
        if (idx < 0) $display("unreachable %0d", idx);
`endif
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q.size() != 0 || evt_valid) && k < 200) begin
            step(1);
            k++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   bad;
        int   p3_base;
        int   l3_base;

        // Monitor: every accepted event is compared with the scoreboard head
        fork
            forever begin
                @(negedge clk);
                if (press[3] === 1'b1) p3_cnt++;
                if (level[3] === 1'b1 && l3_prev === 1'b0) l3_rise++;
                l3_prev = level[3];
                if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL evt_unexpected: got idx=%0d rel=%0d, required no event",
                                 evt_index, evt_rel);
                    end else begin
                        e = q.pop_front();
                        if (evt_index !== e.idx || evt_rel !== e.rel) begin
                            n_fail++;
                            $display("FAIL evt_order: got idx=%0d rel=%0d, required idx=%0d rel=%0d",
                                     evt_index, evt_rel, e.idx, e.rel);
                        end
                    end
                end
            end
        join_none

        // 1: reset with all buttons held, then eight ascending presses
        rst_n     = 1'b0;
        btn       = 8'hFF;
        evt_ready = 1'b0;
        step(3);
        check("rst_level", 32'(level), 32'h00);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) push(i, 1'b0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        step(8);
        check("rst_level_up", 32'(level), 32'hFF);
        drain("rst_drain");
        btn = 8'h00;
        for (int i = 0; i < 8; i++) push_rel(i);
        step(15);
        drain("rst_rel_drain");
        check("rst_level_down", 32'(level), 32'h00);

        // 2: bouncing bit 3 must yield a single press
        p3_base = p3_cnt;
        l3_base = l3_rise;
        push(3, 1'b0);
        for (int k = 0; k < 10; k++) begin
            btn[3] = ~btn[3];
            step(3);
        end
        btn[3] = 1'b1;
        step(20);
        check("bounce_level", 32'(level[3]), 32'd1);
        check("bounce_press_pulses", 32'(p3_cnt - p3_base), 32'd1);
        check("bounce_level_rises", 32'(l3_rise - l3_base), 32'd1);
        drain("bounce_drain");
        btn[3] = 1'b0;
        push_rel(3);
        step(15);
        drain("bounce_rel_drain");

        // 3: backpressure holds the lowest-index event stable
        evt_ready = 1'b0;
        btn[1]    = 1'b1;
        btn[5]    = 1'b1;
        push(1, 1'b0);
        push(5, 1'b0);
        step(15);
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_index", 32'(evt_index), 32'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (!(evt_valid === 1'b1 && evt_index === 3'd1)) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        evt_ready = 1'b1;
        drain("bp_drain");
        check("bp_valid_low", 32'(evt_valid), 32'd0);
        btn[1] = 1'b0;
        btn[5] = 1'b0;
        push_rel(1);
        push_rel(5);
        step(15);
        drain("bp_rel_drain");

        // 4: re-press of a still-pending bit is merged and flags overrun
        evt_ready = 1'b0;
        btn[0]    = 1'b1;
        push(0, 1'b0);
        step(15);
        btn[4] = 1'b1;
        push(4, 1'b0);
        step(15);
        check("ovr_not_yet", 32'(overrun), 32'd0);
        btn[4] = 1'b0;
        push_rel(4);
        step(15);
        btn[4] = 1'b1;
        step(15);
        check("ovr_set", 32'(overrun), 32'd1);
        evt_ready = 1'b1;
        drain("ovr_drain");
        check("ovr_sticky", 32'(overrun), 32'd1);
        btn[0] = 1'b0;
        btn[4] = 1'b0;
        push_rel(0);
        push_rel(4);
        step(15);
        drain("ovr_rel_drain");
        check("ovr_sticky2", 32'(overrun), 32'd1);

        // 5: press and release of bit 6
        btn[6] = 1'b1;
        push(6, 1'b0);
        step(15);
        btn[6] = 1'b0;
        push_rel(6);
        step(15);
        drain("rel_drain");

        // 6: reset while an event is presented drops it and clears overrun
        evt_ready = 1'b0;
        btn[2]    = 1'b1;
        step(15);
        check("mid_valid_pre", 32'(evt_valid), 32'd1);
        check("mid_overrun_pre", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        btn   = 8'h00;
        step(1);
        rst_n = 1'b1;
        check("mid_valid", 32'(evt_valid), 32'd0);
        check("mid_overrun", 32'(overrun), 32'd0);
        check("mid_level", 32'(level), 32'h00);
        evt_ready = 1'b1;
        step(40);
        check("mid_no_stale", 32'(evt_valid), 32'd0);
        check("mid_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
